// File: rtl/rx_buffer_drain_scheduler.sv
// RX ring drain: fetch header, validate length, hand body to DMA, publish new read pointer.
// Latency: occ!=0 in IDLE -> rd_mem_en +1, dma_req +4; dma_done -> rd_addr_extended update +2.
// Backpressure: dma_req held until dma_ack; enable low or empty ring parks the block in IDLE.
`ifndef BF
`define BF 9
`endif

module rx_buffer_drain_scheduler #(
    parameter int MAX_FRAME_BYTES = 9600,
    parameter int CHG_HOLD        = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [`BF+1:0]  commited_wr_address,
    output logic            rd_mem_en,
    output logic [`BF:0]    rd_mem_addr,
    input  logic [63:0]     rd_mem_data,
    output logic            dma_req,
    input  logic            dma_ack,
    input  logic            dma_done,
    output logic [`BF:0]    dma_start_addr,
    output logic [15:0]     dma_qwords,
    output logic [31:0]     dma_byte_count,
    output logic [`BF+1:0]  rd_addr_extended,
    output logic            rd_addr_change,
    output logic [31:0]     frames_sent,
    output logic [31:0]     bad_hdr_count
);

    localparam int          PTR_W     = `BF + 2;
    localparam int          ADDR_W    = `BF + 1;
    localparam int          HOLD_W    = $clog2(CHG_HOLD + 1);
    localparam logic [31:0] MAX_BYTES = 32'(MAX_FRAME_BYTES);

    typedef struct packed {
        logic [31:0] byte_count;
        logic [31:0] rsvd;
    } hdr_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_HDR,
        S_WAIT_HDR,
        S_CHECK,
        S_REQ,
        S_XFER,
        S_ADVANCE,
        S_ERR,
        S_HOLD
    } state_t;

    state_t            state;
    state_t            next_state;
    hdr_t              hdr_word;
    logic [31:0]       hdr_len;
    logic [PTR_W-1:0]  occ;
    logic [PTR_W-1:0]  occ_snap;
    logic [32:0]       len_round;
    logic [29:0]       q_calc;
    logic [30:0]       need_words;
    logic              hdr_bad;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_last;
    logic              rd_mem_en_nxt;
    logic              dma_req_nxt;
    logic              chg_nxt;
    logic              unused_bits;

    assign hdr_word   = rd_mem_data;
    assign occ        = commited_wr_address - rd_addr_extended;
    assign len_round  = {1'b0, hdr_len} + 33'd7;
    assign q_calc     = len_round[32:3];
    assign need_words = {1'b0, q_calc} + 31'd1;
    // Header plus body must already be committed, otherwise the ring is treated as corrupt.
    assign hdr_bad    = (hdr_len == 32'd0) || (hdr_len > MAX_BYTES) ||
                        (need_words > 31'(occ_snap));
    assign hold_last  = (hold_cnt == HOLD_W'(CHG_HOLD - 1));
    assign unused_bits = &{1'b0, hdr_word.rsvd, len_round[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (enable && (occ != '0)) next_state = S_RD_HDR;
            S_RD_HDR:   next_state = S_WAIT_HDR;
            S_WAIT_HDR: next_state = S_CHECK;
            S_CHECK:    next_state = hdr_bad ? S_ERR : S_REQ;
            S_REQ:      if (dma_ack) next_state = dma_done ? S_ADVANCE : S_XFER;
            S_XFER:     if (dma_done) next_state = S_ADVANCE;
            S_ADVANCE:  next_state = S_HOLD;
            S_ERR:      next_state = S_HOLD;
            S_HOLD:     if (hold_last) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Strobes are decoded from next_state so the registered copies line up with the state.
    always_comb begin
        rd_mem_en_nxt = 1'b0;
        dma_req_nxt   = 1'b0;
        chg_nxt       = 1'b0;
        case (next_state)
            S_RD_HDR: rd_mem_en_nxt = 1'b1;
            S_REQ:    dma_req_nxt   = 1'b1;
            S_HOLD:   chg_nxt       = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_mem_en        <= 1'b0;
            rd_mem_addr      <= '0;
            dma_req          <= 1'b0;
            dma_start_addr   <= '0;
            dma_qwords       <= '0;
            dma_byte_count   <= '0;
            rd_addr_extended <= '0;
            rd_addr_change   <= 1'b0;
            frames_sent      <= '0;
            bad_hdr_count    <= '0;
            hdr_len          <= '0;
            occ_snap         <= '0;
            hold_cnt         <= '0;
        end else begin
            rd_mem_en      <= rd_mem_en_nxt;
            dma_req        <= dma_req_nxt;
            rd_addr_change <= chg_nxt;

            if (rd_mem_en_nxt) begin
                rd_mem_addr <= rd_addr_extended[ADDR_W-1:0];
            end

            if (state == S_WAIT_HDR) begin
                hdr_len  <= hdr_word.byte_count;
                occ_snap <= occ;
            end

            if ((state == S_CHECK) && !hdr_bad) begin
                dma_start_addr <= rd_addr_extended[ADDR_W-1:0] + ADDR_W'(1);
                dma_qwords     <= q_calc[15:0];
                dma_byte_count <= hdr_len;
            end

            if (state == S_ADVANCE) begin
                rd_addr_extended <= rd_addr_extended + PTR_W'(dma_qwords) + PTR_W'(1);
                frames_sent      <= frames_sent + 32'd1;
            end

            // A bad header leaves no trustworthy frame boundary: drop everything committed.
            if (state == S_ERR) begin
                rd_addr_extended <= rd_addr_extended + occ_snap;
                bad_hdr_count    <= bad_hdr_count + 32'd1;
            end

            if (state == S_HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_buffer_drain_scheduler.sv
// Bench for rx_buffer_drain_scheduler: ring memory model, scripted DMA engine, queue scoreboard.
`timescale 1ns/1ps
`ifndef BF
`define BF 9
`endif

module tb_rx_buffer_drain_scheduler;

    localparam int PTR_W    = `BF + 2;
    localparam int ADDR_W   = `BF + 1;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int CHG_HOLD = 4;

    typedef struct {
        logic [ADDR_W-1:0] start;
        logic [15:0]       q;
        logic [31:0]       bytes;
        logic [PTR_W-1:0]  next;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic [PTR_W-1:0]  commit;
    logic              rd_mem_en;
    logic [ADDR_W-1:0] rd_mem_addr;
    logic [63:0]       rd_mem_data;
    logic              dma_req;
    logic              dma_ack;
    logic              dma_done;
    logic [ADDR_W-1:0] dma_start_addr;
    logic [15:0]       dma_qwords;
    logic [31:0]       dma_byte_count;
    logic [PTR_W-1:0]  rd_addr_extended;
    logic              rd_addr_change;
    logic [31:0]       frames_sent;
    logic [31:0]       bad_hdr_count;

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] rd_lat_addr;
    logic [PTR_W-1:0]  m_ptr;
    exp_t              exp_q[$];

    int checks;
    int errors;
    int cyc;
    int rden_cnt, rden_cyc, chg_cnt, req_cnt, upd_cyc, ptr_glitch;
    logic [PTR_W-1:0] prev_ptr;
    logic             prev_chg;

    rx_buffer_drain_scheduler #(
        .MAX_FRAME_BYTES(9600),
        .CHG_HOLD       (CHG_HOLD)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .commited_wr_address(commit),
        .rd_mem_en          (rd_mem_en),
        .rd_mem_addr        (rd_mem_addr),
        .rd_mem_data        (rd_mem_data),
        .dma_req            (dma_req),
        .dma_ack            (dma_ack),
        .dma_done           (dma_done),
        .dma_start_addr     (dma_start_addr),
        .dma_qwords         (dma_qwords),
        .dma_byte_count     (dma_byte_count),
        .rd_addr_extended   (rd_addr_extended),
        .rd_addr_change     (rd_addr_change),
        .frames_sent        (frames_sent),
        .bad_hdr_count      (bad_hdr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ring read port: data only valid in the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (rd_mem_en === 1'b1) begin
            rd_lat_addr = rd_mem_addr;
            #1 rd_mem_data = mem[rd_lat_addr];
        end else begin
            #1 rd_mem_data = {32'hFFFF_FFFF, 32'h0BAD_0BAD};
        end
    end

    always @(posedge clk) begin
        if (rd_mem_en === 1'b1) begin
            rden_cnt++;
            rden_cyc = cyc;
        end
        if (rd_addr_change === 1'b1) chg_cnt++;
        if (dma_req === 1'b1) req_cnt++;
        if (reset_n && prev_chg && (rd_addr_extended != prev_ptr)) ptr_glitch++;
        if (rd_addr_extended != prev_ptr) upd_cyc = cyc;
        prev_ptr = rd_addr_extended;
        prev_chg = rd_addr_change;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(output int ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dma_req === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Called at the negedge of the first request cycle; returns at the negedge after done.
    task automatic serve(input int ack_at, input int done_at, input int drop_en_at);
        for (int t = 0; t <= done_at; t++) begin
            dma_ack  = (t == ack_at);
            dma_done = (t == done_at);
            if (t == drop_en_at) enable = 1'b0;
            @(negedge clk);
        end
        dma_ack  = 1'b0;
        dma_done = 1'b0;
    endtask

    task automatic post_frame(input logic [31:0] len);
        exp_t e;
        int   q;
        q = int'((len + 32'd7) / 32'd8);
        mem[m_ptr[ADDR_W-1:0]] = {len, $urandom()};
        e.start = ADDR_W'(int'(m_ptr) + 1);
        e.q     = 16'(q);
        e.bytes = len;
        e.next  = PTR_W'(int'(m_ptr) + 1 + q);
        m_ptr   = e.next;
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        e = '{default: '0};
        if (exp_q.size() > 0) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if ({rd_mem_en, rd_mem_addr, dma_req, dma_start_addr, dma_qwords, dma_byte_count,
             rd_addr_extended, rd_addr_change, frames_sent, bad_hdr_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {rd_mem_en, dma_req,
                     rd_addr_extended, rd_addr_change, frames_sent, bad_hdr_count});
        end
        reset_n = 1'b1;
        tick(3);
        checks++;
        if ({rd_mem_en, dma_req, rd_addr_extended, rd_addr_change, frames_sent} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h required 0",
                     {rd_mem_en, dma_req, rd_addr_extended, rd_addr_change, frames_sent});
        end
        checks++;
        if (rden_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_read: got %0d reads required 0", rden_cnt);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   ok, t0, req0, chg0;
        post_frame(32'd64);
        commit = m_ptr;
        t0 = cyc;
        @(negedge clk);
        checks++;
        if (rd_mem_en !== 1'b1 || rd_mem_addr !== '0) begin
            errors++;
            $display("FAIL basic_rden: got en=%b addr=%0d required en=1 addr=0", rd_mem_en, rd_mem_addr);
        end
        wait_req(ok);
        checks++;
        if (!ok || (cyc - t0) != 4) begin
            errors++;
            $display("FAIL basic_req_latency: got %0d cycles (ok=%0d) required 4", cyc - t0, ok);
        end
        pop_exp(e);
        checks++;
        if ({dma_start_addr, dma_qwords, dma_byte_count} !== {e.start, e.q, e.bytes}) begin
            errors++;
            $display("FAIL basic_desc: got %0d/%0d/%0d required %0d/%0d/%0d", dma_start_addr,
                     dma_qwords, dma_byte_count, e.start, e.q, e.bytes);
        end
        req0 = req_cnt;
        serve(2, 10, -1);
        checks++;
        if (req_cnt - req0 != 3) begin
            errors++;
            $display("FAIL basic_req_hold: got %0d request cycles required 3", req_cnt - req0);
        end
        checks++;
        if (rd_addr_extended !== '0 || rd_addr_change !== 1'b0 || dma_qwords !== e.q ||
            dma_start_addr !== e.start) begin
            errors++;
            $display("FAIL basic_ptr_pre: got ptr=%0d chg=%b q=%0d required ptr=0 chg=0 q=%0d",
                     rd_addr_extended, rd_addr_change, dma_qwords, e.q);
        end
        @(negedge clk);
        checks++;
        if (rd_addr_extended !== e.next || rd_addr_change !== 1'b1 || frames_sent !== 32'd1) begin
            errors++;
            $display("FAIL basic_ptr_upd: got ptr=%0d chg=%b sent=%0d required ptr=%0d chg=1 sent=1",
                     rd_addr_extended, rd_addr_change, frames_sent, e.next);
        end
        chg0 = chg_cnt;
        tick(6);
        checks++;
        if (chg_cnt - chg0 != CHG_HOLD) begin
            errors++;
            $display("FAIL basic_chg_width: got %0d cycles required %0d", chg_cnt - chg0, CHG_HOLD);
        end
    endtask

    task automatic test_bad_header();
        int          bad_len [4];
        int          bad_occ [4];
        int          req0, chg0;
        logic [31:0] bad0;
        bad_len = '{0, 10000, 800, 0};
        bad_occ = '{11, 10, 5, 987};
        for (int i = 0; i < 4; i++) begin
            mem[m_ptr[ADDR_W-1:0]] = {32'(bad_len[i]), 32'h0};
            req0  = req_cnt;
            chg0  = chg_cnt;
            bad0  = bad_hdr_count;
            m_ptr = PTR_W'(int'(m_ptr) + bad_occ[i]);
            commit = m_ptr;
            tick(12);
            checks++;
            if (req_cnt != req0) begin
                errors++;
                $display("FAIL bad_noreq[%0d]: got %0d requests required 0", i, req_cnt - req0);
            end
            checks++;
            if (rd_addr_extended !== m_ptr || bad_hdr_count !== bad0 + 32'd1) begin
                errors++;
                $display("FAIL bad_ptr[%0d]: got ptr=%0d bad=%0d required ptr=%0d bad=%0d",
                         i, rd_addr_extended, bad_hdr_count, m_ptr, bad0 + 32'd1);
            end
            checks++;
            if (chg_cnt - chg0 != CHG_HOLD) begin
                errors++;
                $display("FAIL bad_chg[%0d]: got %0d cycles required %0d", i, chg_cnt - chg0, CHG_HOLD);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   ok;
        post_frame(32'd13);
        commit = m_ptr;
        wait_req(ok);
        pop_exp(e);
        checks++;
        if (!ok || dma_start_addr !== 10'd1023 || dma_qwords !== 16'd2 ||
            {dma_start_addr, dma_qwords} !== {e.start, e.q}) begin
            errors++;
            $display("FAIL wrap_desc: got start=%0d q=%0d required start=1023 q=2", dma_start_addr, dma_qwords);
        end
        serve(1, 4, -1);
        @(negedge clk);
        checks++;
        if (rd_addr_extended !== 11'd1025 || frames_sent !== 32'd2) begin
            errors++;
            $display("FAIL wrap_ptr: got ptr=%0d sent=%0d required ptr=1025 sent=2",
                     rd_addr_extended, frames_sent);
        end
    endtask

    task automatic test_ack_done_same();
        exp_t e;
        int   ok, r0;
        tick(CHG_HOLD + 2);
        r0 = rden_cnt;
        post_frame(32'd8);
        commit = m_ptr;
        wait_req(ok);
        pop_exp(e);
        checks++;
        if (!ok || rden_cnt != r0 + 1 || rd_mem_addr !== 10'd1) begin
            errors++;
            $display("FAIL wrap_next_addr: got addr=%0d required 1", rd_mem_addr);
        end
        serve(1, 1, -1);
        checks++;
        if (rd_addr_extended !== 11'd1025) begin
            errors++;
            $display("FAIL same_pre: got ptr=%0d required 1025", rd_addr_extended);
        end
        @(negedge clk);
        checks++;
        if (rd_addr_extended !== e.next || rd_addr_change !== 1'b1) begin
            errors++;
            $display("FAIL same_upd: got ptr=%0d chg=%b required ptr=%0d chg=1",
                     rd_addr_extended, rd_addr_change, e.next);
        end
    endtask

    task automatic test_full_buffer();
        exp_t e;
        int   ok;
        tick(CHG_HOLD + 2);
        post_frame(32'd8184);
        commit = m_ptr;
        wait_req(ok);
        pop_exp(e);
        checks++;
        if (!ok || {dma_start_addr, dma_qwords, dma_byte_count} !== {e.start, e.q, e.bytes}) begin
            errors++;
            $display("FAIL full_desc: got %0d/%0d/%0d required %0d/%0d/%0d", dma_start_addr,
                     dma_qwords, dma_byte_count, e.start, e.q, e.bytes);
        end
        serve(0, 3, -1);
        @(negedge clk);
        checks++;
        if (rd_addr_extended !== 11'd3) begin
            errors++;
            $display("FAIL full_ptr: got %0d required 3", rd_addr_extended);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   ok;
        tick(CHG_HOLD + 2);
        post_frame(32'd24);
        post_frame(32'd1);
        post_frame(32'd40);
        commit = m_ptr;
        for (int i = 0; i < 3; i++) begin
            wait_req(ok);
            pop_exp(e);
            checks++;
            if (!ok || {dma_start_addr, dma_qwords, dma_byte_count} !== {e.start, e.q, e.bytes}) begin
                errors++;
                $display("FAIL b2b_desc[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", i, dma_start_addr,
                         dma_qwords, dma_byte_count, e.start, e.q, e.bytes);
            end
            if (i > 0) begin
                checks++;
                if (rden_cyc - upd_cyc != CHG_HOLD + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d",
                             i, rden_cyc - upd_cyc, CHG_HOLD + 1);
                end
            end
            serve(1, 3, -1);
            @(negedge clk);
            checks++;
            if (rd_addr_extended !== e.next) begin
                errors++;
                $display("FAIL b2b_ptr[%0d]: got %0d required %0d", i, rd_addr_extended, e.next);
            end
        end
        checks++;
        if (ptr_glitch != 0) begin
            errors++;
            $display("FAIL b2b_ptr_frozen: got %0d updates during change pulse required 0", ptr_glitch);
        end
    endtask

    task automatic test_enable_drop();
        exp_t        e;
        int          ok, r0;
        logic [31:0] sent0;
        tick(CHG_HOLD + 2);
        sent0 = frames_sent;
        post_frame(32'd16);
        post_frame(32'd8);
        commit = m_ptr;
        wait_req(ok);
        pop_exp(e);
        checks++;
        if (!ok || {dma_start_addr, dma_qwords} !== {e.start, e.q}) begin
            errors++;
            $display("FAIL en_desc: got %0d/%0d required %0d/%0d", dma_start_addr, dma_qwords, e.start, e.q);
        end
        serve(1, 5, 2);
        @(negedge clk);
        checks++;
        if (rd_addr_extended !== e.next || frames_sent !== sent0 + 32'd1) begin
            errors++;
            $display("FAIL en_complete: got ptr=%0d sent=%0d required ptr=%0d sent=%0d",
                     rd_addr_extended, frames_sent, e.next, sent0 + 32'd1);
        end
        r0 = rden_cnt;
        tick(30);
        checks++;
        if (rden_cnt != r0 || rd_addr_extended !== e.next || commit == rd_addr_extended) begin
            errors++;
            $display("FAIL en_idle: got reads=%0d ptr=%0d required reads=0 ptr=%0d",
                     rden_cnt - r0, rd_addr_extended, e.next);
        end
    endtask

    task automatic test_reset_mid();
        int ok, chg0, r0;
        enable = 1'b1;
        wait_req(ok);
        reset_n = 1'b0;
        commit  = '0;
        exp_q.delete();
        #1;
        checks++;
        if (!ok || {rd_mem_en, rd_mem_addr, dma_req, dma_start_addr, dma_qwords, dma_byte_count,
                    rd_addr_extended, rd_addr_change, frames_sent, bad_hdr_count} !== '0) begin
            errors++;
            $display("FAIL rst_mid_zero: got req=%b ptr=%0d sent=%0d ok=%0d required all 0",
                     dma_req, rd_addr_extended, frames_sent, ok);
        end
        tick(2);
        chg0 = chg_cnt;
        r0   = rden_cnt;
        reset_n = 1'b1;
        tick(20);
        checks++;
        if (chg_cnt != chg0 || rden_cnt != r0) begin
            errors++;
            $display("FAIL rst_no_chg: got chg=%0d reads=%0d required 0 0", chg_cnt - chg0, rden_cnt - r0);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b1;
        commit      = '0;
        dma_ack     = 1'b0;
        dma_done    = 1'b0;
        rd_mem_data = '0;
        m_ptr       = '0;
        prev_ptr    = '0;
        prev_chg    = 1'b0;
        cyc = 0; checks = 0; errors = 0;
        rden_cnt = 0; rden_cyc = 0; chg_cnt = 0; req_cnt = 0; upd_cyc = 0; ptr_glitch = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom(), $urandom()};

        test_reset();
        test_basic();
        test_bad_header();
        test_wrap();
        test_ack_done_same();
        test_full_buffer();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
